dma_tx_arbiter: RTL and testbench
=================================

DMA_TX_ARBITER -- requirements
Module: dma_tx_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256, giving the TDATA width of all stream ports.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, giving the TUSER width of all stream ports.
REQ-003 SHALL have port AXIS_ACLK, input, 1 bit: the single clock; everything is rising-edge synchronous to it.
REQ-004 SHALL have port AXIS_RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports Sn_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST, inputs, for n=0..3, widths C_AXIS_DATA_WIDTH / C_AXIS_DATA_WIDTH/8 / C_AXIS_TUSER_WIDTH / 1 / 1: the four requester packet streams.
REQ-006 SHALL have port Sn_AXIS_TREADY, output, 1 bit per n=0..3: backpressure to requester n.
REQ-007 SHALL have ports M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST, outputs, same widths as REQ-005: the merged stream to the DMA engine's S_AXIS port.
REQ-008 SHALL have port M_AXIS_TREADY, input, 1 bit: backpressure from the DMA engine.
REQ-009 SHALL have port ARB_PORT_EN, input, 4 bits: per-port grant enable.
REQ-010 SHALL have port ARB_GRANT, output, 2 bits: index of the currently granted port.
REQ-011 SHALL have port ARB_BUSY, output, 1 bit: high while in XFER.
REQ-012 SHALL have port STAT_PKT_CNT, output, 128 bits: four 32-bit packet counters, port n at bits [32n+31:32n].

Function
REQ-013 SHALL implement an FSM with exactly two states, IDLE and XFER.
REQ-014 In IDLE, M_AXIS_TVALID and all Sn_AXIS_TREADY SHALL be 0.
REQ-015 In IDLE, when any port n has Sn_AXIS_TVALID=1 and ARB_PORT_EN[n]=1, the block SHALL register the grant to the first such port searching rr_ptr, rr_ptr+1, ... mod 4, then enter XFER on the next cycle.
REQ-016 Arbitration latency SHALL be exactly one cycle: the first beat is presented on M_AXIS the cycle after the request is seen in IDLE.
REQ-017 In XFER, M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST SHALL equal the granted port's inputs combinationally.
REQ-018 In XFER, S[grant]_AXIS_TREADY SHALL equal M_AXIS_TREADY; all other TREADY SHALL be 0.
REQ-019 A beat SHALL be accepted when M_AXIS_TVALID=1 and M_AXIS_TREADY=1 in the same cycle.
REQ-020 On acceptance of a beat with TLAST=1, the block SHALL set rr_ptr=(grant+1) mod 4, increment counter[grant] by 1, and return to IDLE.
REQ-021 The grant SHALL NOT change mid-packet: deassertion of TVALID by the granted source, or deassertion of its ARB_PORT_EN bit, SHALL only stall the transfer; the packet is never aborted.
REQ-022 A single-beat packet (TLAST on the first beat) SHALL be supported, giving IDLE -> XFER -> IDLE.
REQ-023 One idle bubble cycle SHALL occur between consecutive packets; this is the decided throughput.
REQ-024 Packet counters SHALL wrap from 0xFFFFFFFF to 0 with no saturation.
REQ-025 Ports whose ARB_PORT_EN bit is 0 SHALL never be newly granted.
REQ-026 When no port is eligible, the block SHALL remain in IDLE and rr_ptr SHALL be unchanged.
REQ-027 ARB_GRANT SHALL hold the last grant value while in IDLE.

Reset
REQ-028 While AXIS_RESET=1 on a clock edge, the block SHALL set state=IDLE, rr_ptr=0, ARB_GRANT=0, and all counters=0.
REQ-029 Outputs SHALL then read M_AXIS_TVALID=0, all Sn_AXIS_TREADY=0, ARB_BUSY=0, STAT_PKT_CNT=0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet without emitting TLAST; the downstream DMA engine is reset in the same domain.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the port count constant (4), the counter width (32), and the port-index width (2).
REQ-032 A sub-module rr_pick SHALL be used: combinational, taking a 4-bit request vector and a 2-bit pointer, and returning a 2-bit index plus a valid flag.
REQ-033 No data buffering SHALL be instantiated; the datapath is a registered-select multiplexer only.

Verification
REQ-034 Reset, then S0 sends a 3-beat packet with M_AXIS_TREADY=1 -> beats appear on cycles 2-4 after TVALID; counter0=1; ARB_BUSY low after TLAST.
REQ-035 All four ports hold single-beat packets continuously -> grant order 0,1,2,3,0; each counter=2 after 8 packets.
REQ-036 Granted port S1, M_AXIS_TREADY toggles 1,0,1 mid-packet while S2 is valid -> S2_AXIS_TREADY stays 0; S1 data is unchanged while stalled; no beat is lost or duplicated.
REQ-037 ARB_PORT_EN=4'b1011 with all ports valid -> port 2 is never granted; clearing EN[1] mid-packet on port 1 -> that packet still completes.
REQ-038 Counter preloaded by 0xFFFFFFFF packets via a forced value, then one more packet -> counter wraps to 0.
REQ-039 Assert AXIS_RESET during beat 2 of a 4-beat packet -> next cycle all TREADY=0, M_AXIS_TVALID=0, counters=0, and the next grant starts at port 0.

Source files
------------

// File: rtl/dma_tx_arbiter_pkg.sv
// dma_tx_arbiter_pkg: shared FSM encoding and sizing constants for the DMA TX arbiter
package dma_tx_arbiter_pkg;
    localparam int NUM_PORTS = 4;
    localparam int CNT_W     = 32;
    localparam int IDX_W     = 2;
    typedef enum logic {IDLE, XFER} state_t;
endpackage

// File: rtl/dma_tx_arbiter_rr_pick.sv
// rr_pick: round-robin pick (req, ptr -> idx, vld), first request at or after ptr mod 4
module rr_pick
    import dma_tx_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     idx,
    output logic                 vld
);
    logic [NUM_PORTS-1:0] rot;
    logic [IDX_W-1:0]     off;
    assign rot = NUM_PORTS'({req, req} >> ptr);
    assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign idx = ptr + off;
    assign vld = |req;
endmodule

// File: rtl/dma_tx_arbiter.sv
// dma_tx_arbiter: merges four AXI-Stream packet sources (S0..S3) onto one M stream by packet-level round robin, with grant/busy status and per-port packet counters
module dma_tx_arbiter
    import dma_tx_arbiter_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_RESET,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    S0_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S0_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S0_AXIS_TUSER,
    input  logic                            S0_AXIS_TVALID,
    input  logic                            S0_AXIS_TLAST,
    output logic                            S0_AXIS_TREADY,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    S1_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S1_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S1_AXIS_TUSER,
    input  logic                            S1_AXIS_TVALID,
    input  logic                            S1_AXIS_TLAST,
    output logic                            S1_AXIS_TREADY,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    S2_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S2_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S2_AXIS_TUSER,
    input  logic                            S2_AXIS_TVALID,
    input  logic                            S2_AXIS_TLAST,
    output logic                            S2_AXIS_TREADY,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    S3_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S3_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S3_AXIS_TUSER,
    input  logic                            S3_AXIS_TVALID,
    input  logic                            S3_AXIS_TLAST,
    output logic                            S3_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    input  logic [NUM_PORTS-1:0]            ARB_PORT_EN,
    output logic [IDX_W-1:0]                ARB_GRANT,
    output logic                            ARB_BUSY,
    output logic [NUM_PORTS*CNT_W-1:0]      STAT_PKT_CNT
);
    logic [NUM_PORTS-1:0][C_AXIS_DATA_WIDTH-1:0]   s_tdata;
    logic [NUM_PORTS-1:0][C_AXIS_DATA_WIDTH/8-1:0] s_tstrb;
    logic [NUM_PORTS-1:0][C_AXIS_TUSER_WIDTH-1:0]  s_tuser;
    logic [NUM_PORTS-1:0]                          s_tvalid;
    logic [NUM_PORTS-1:0]                          s_tlast;
    logic [NUM_PORTS-1:0]                          s_tready;
    logic [NUM_PORTS-1:0][CNT_W-1:0]               cnt;
    logic [IDX_W-1:0]                              grant;
    logic [IDX_W-1:0]                              rr_ptr;
    logic [IDX_W-1:0]                              pick_idx;
    logic                                          pick_vld;
    logic                                          acc_last;
    state_t                                        state;
    state_t                                        state_nxt;
    assign s_tdata  = {S3_AXIS_TDATA, S2_AXIS_TDATA, S1_AXIS_TDATA, S0_AXIS_TDATA};
    assign s_tstrb  = {S3_AXIS_TSTRB, S2_AXIS_TSTRB, S1_AXIS_TSTRB, S0_AXIS_TSTRB};
    assign s_tuser  = {S3_AXIS_TUSER, S2_AXIS_TUSER, S1_AXIS_TUSER, S0_AXIS_TUSER};
    assign s_tvalid = {S3_AXIS_TVALID, S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID};
    assign s_tlast  = {S3_AXIS_TLAST, S2_AXIS_TLAST, S1_AXIS_TLAST, S0_AXIS_TLAST};
    assign {S3_AXIS_TREADY, S2_AXIS_TREADY, S1_AXIS_TREADY, S0_AXIS_TREADY} = s_tready;
    rr_pick u_pick (
        .req (s_tvalid & ARB_PORT_EN),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );
    assign acc_last = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_RESET) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE) ? (pick_vld ? XFER : IDLE) : (acc_last ? IDLE : XFER);
    end
    always_comb begin
        ARB_BUSY      = state == XFER;
        M_AXIS_TDATA  = s_tdata[grant];
        M_AXIS_TSTRB  = s_tstrb[grant];
        M_AXIS_TUSER  = s_tuser[grant];
        M_AXIS_TLAST  = s_tlast[grant];
        M_AXIS_TVALID = ARB_BUSY & s_tvalid[grant];
        s_tready      = ARB_BUSY ? ({3'b000, M_AXIS_TREADY} << grant) : '0;
    end
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_RESET) begin
            grant  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && pick_vld) grant <= pick_idx;
            if (acc_last) begin
                rr_ptr     <= grant + 2'd1;
                cnt[grant] <= cnt[grant] + CNT_W'(1);
            end
        end
    end
    assign ARB_GRANT    = grant;
    assign STAT_PKT_CNT = cnt;
endmodule

// File: tb/tb_dma_tx_arbiter.sv
// tb_dma_tx_arbiter: directed self-checking bench for dma_tx_arbiter
module tb_dma_tx_arbiter;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;
    logic                     clk = 1'b0;
    logic                     rst;
    logic [DW-1:0]            s_tdata [4];
    logic [SW-1:0]            s_tstrb [4];
    logic [UW-1:0]            s_tuser [4];
    logic [3:0]               s_tvalid;
    logic [3:0]               s_tlast;
    wire  [3:0]               s_tready;
    logic [DW-1:0]            m_tdata;
    logic [SW-1:0]            m_tstrb;
    logic [UW-1:0]            m_tuser;
    logic                     m_tvalid;
    logic                     m_tlast;
    logic                     m_tready;
    logic [3:0]               en;
    logic [1:0]               grant;
    logic                     busy;
    logic [127:0]             stat;
    logic [DW-1:0]            acc_q [$];
    int                       chk = 0;
    int                       fail = 0;
    always #5 clk = ~clk;
    dma_tx_arbiter dut (
        .AXIS_ACLK      (clk),
        .AXIS_RESET     (rst),
        .S0_AXIS_TDATA  (s_tdata[0]), .S0_AXIS_TSTRB (s_tstrb[0]), .S0_AXIS_TUSER (s_tuser[0]),
        .S0_AXIS_TVALID (s_tvalid[0]), .S0_AXIS_TLAST (s_tlast[0]), .S0_AXIS_TREADY (s_tready[0]),
        .S1_AXIS_TDATA  (s_tdata[1]), .S1_AXIS_TSTRB (s_tstrb[1]), .S1_AXIS_TUSER (s_tuser[1]),
        .S1_AXIS_TVALID (s_tvalid[1]), .S1_AXIS_TLAST (s_tlast[1]), .S1_AXIS_TREADY (s_tready[1]),
        .S2_AXIS_TDATA  (s_tdata[2]), .S2_AXIS_TSTRB (s_tstrb[2]), .S2_AXIS_TUSER (s_tuser[2]),
        .S2_AXIS_TVALID (s_tvalid[2]), .S2_AXIS_TLAST (s_tlast[2]), .S2_AXIS_TREADY (s_tready[2]),
        .S3_AXIS_TDATA  (s_tdata[3]), .S3_AXIS_TSTRB (s_tstrb[3]), .S3_AXIS_TUSER (s_tuser[3]),
        .S3_AXIS_TVALID (s_tvalid[3]), .S3_AXIS_TLAST (s_tlast[3]), .S3_AXIS_TREADY (s_tready[3]),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TSTRB   (m_tstrb),
        .M_AXIS_TUSER   (m_tuser),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TLAST   (m_tlast),
        .M_AXIS_TREADY  (m_tready),
        .ARB_PORT_EN    (en),
        .ARB_GRANT      (grant),
        .ARB_BUSY       (busy),
        .STAT_PKT_CNT   (stat)
    );
    always @(posedge clk) if (!rst && m_tvalid && m_tready) acc_q.push_back(m_tdata);
    function automatic logic [DW-1:0] beat(input int n, input logic [7:0] t);
        return {56'(n + 1), 192'h0, t};
    endfunction
    task automatic drive(input int n, input logic v, input logic l, input logic [7:0] t);
        s_tvalid[n] = v;
        s_tlast[n]  = l;
        s_tdata[n]  = beat(n, t);
        s_tuser[n]  = {120'(n), t};
        s_tstrb[n]  = {8'(n), 24'hFFFFFF};
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_tready = 1'b1;
        en = 4'hF;
        for (int n = 0; n < 4; n++) drive(n, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        acc_q.delete();
    endtask
    task automatic test_reset();
        do_reset();
        #1;
        chk++; if (busy !== 1'b0) begin fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        chk++; if (m_tvalid !== 1'b0) begin fail++; $display("FAIL reset_tvalid: got %b exp 0", m_tvalid); end
        chk++; if (s_tready !== 4'h0) begin fail++; $display("FAIL reset_tready: got %b exp 0000", s_tready); end
        chk++; if (grant !== 2'd0) begin fail++; $display("FAIL reset_grant: got %0d exp 0", grant); end
        chk++; if (stat !== 128'h0) begin fail++; $display("FAIL reset_stat: got %h exp 0", stat); end
    endtask
    task automatic test_basic();
        do_reset();
        @(negedge clk); drive(0, 1'b1, 1'b0, 8'hA0); #1;
        chk++; if (m_tvalid !== 1'b0) begin fail++; $display("FAIL basic_latency: tvalid got %b exp 0", m_tvalid); end
        @(negedge clk); #1;
        chk++; if (m_tvalid !== 1'b1 || m_tdata !== beat(0, 8'hA0)) begin fail++; $display("FAIL basic_beat0: tvalid %b data %h exp 1 %h", m_tvalid, m_tdata, beat(0, 8'hA0)); end
        chk++; if (s_tready !== 4'b0001 || busy !== 1'b1) begin fail++; $display("FAIL basic_ready: tready %b busy %b exp 0001 1", s_tready, busy); end
        @(negedge clk); drive(0, 1'b1, 1'b0, 8'hA1); #1;
        chk++; if (m_tdata !== beat(0, 8'hA1) || m_tlast !== 1'b0) begin fail++; $display("FAIL basic_beat1: data %h last %b exp %h 0", m_tdata, m_tlast, beat(0, 8'hA1)); end
        @(negedge clk); drive(0, 1'b1, 1'b1, 8'hA2); #1;
        chk++; if (m_tlast !== 1'b1 || m_tuser !== {120'd0, 8'hA2} || m_tstrb !== 32'h00FFFFFF) begin fail++; $display("FAIL basic_beat2: last %b user %h strb %h exp 1 a2 00ffffff", m_tlast, m_tuser, m_tstrb); end
        @(negedge clk); drive(0, 1'b0, 1'b0, 8'h00); #1;
        chk++; if (busy !== 1'b0) begin fail++; $display("FAIL basic_busy_end: got %b exp 0", busy); end
        chk++; if (stat !== 128'h1) begin fail++; $display("FAIL basic_cnt: got %h exp 1", stat); end
        chk++; if (acc_q.size() != 3) begin fail++; $display("FAIL basic_beats: got %0d exp 3", acc_q.size()); end
    endtask
    task automatic test_all_ports();
        do_reset();
        @(negedge clk);
        for (int n = 0; n < 4; n++) drive(n, 1'b1, 1'b1, 8'(n));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            chk++; if (busy !== 1'b1 || grant !== 2'(k % 4) || m_tdata !== beat(k % 4, 8'(k % 4))) begin fail++; $display("FAIL rr_grant%0d: busy %b grant %0d exp 1 %0d", k, busy, grant, k % 4); end
            @(negedge clk);
            if (k == 7) for (int n = 0; n < 4; n++) drive(n, 1'b0, 1'b0, 8'h00);
            #1;
            chk++; if (busy !== 1'b0) begin fail++; $display("FAIL rr_bubble%0d: busy %b exp 0", k, busy); end
        end
        chk++; if (stat !== {32'd2, 32'd2, 32'd2, 32'd2}) begin fail++; $display("FAIL rr_counts: got %h exp all 2", stat); end
    endtask
    task automatic test_stall();
        do_reset();
        @(negedge clk); drive(1, 1'b1, 1'b0, 8'hB0); drive(2, 1'b1, 1'b1, 8'hC0);
        @(negedge clk); #1;
        chk++; if (grant !== 2'd1 || m_tdata !== beat(1, 8'hB0) || s_tready !== 4'b0010) begin fail++; $display("FAIL stall_b0: grant %0d tready %b exp 1 0010", grant, s_tready); end
        @(negedge clk); drive(1, 1'b1, 1'b0, 8'hB1); m_tready = 1'b0; #1;
        chk++; if (s_tready !== 4'b0000 || m_tvalid !== 1'b1) begin fail++; $display("FAIL stall_hold: tready %b tvalid %b exp 0000 1", s_tready, m_tvalid); end
        @(negedge clk); m_tready = 1'b1; #1;
        chk++; if (m_tdata !== beat(1, 8'hB1) || s_tready !== 4'b0010) begin fail++; $display("FAIL stall_resume: data %h tready %b exp %h 0010", m_tdata, s_tready, beat(1, 8'hB1)); end
        @(negedge clk); drive(1, 1'b1, 1'b1, 8'hB2); #1;
        chk++; if (m_tlast !== 1'b1 || s_tready[2] !== 1'b0) begin fail++; $display("FAIL stall_last: last %b s2ready %b exp 1 0", m_tlast, s_tready[2]); end
        @(negedge clk); drive(1, 1'b0, 1'b0, 8'h00); #1;
        chk++; if (busy !== 1'b0 || grant !== 2'd1) begin fail++; $display("FAIL stall_idle_hold: busy %b grant %0d exp 0 1", busy, grant); end
        chk++; if (acc_q.size() != 3 || acc_q[0] !== beat(1, 8'hB0) || acc_q[1] !== beat(1, 8'hB1) || acc_q[2] !== beat(1, 8'hB2)) begin fail++; $display("FAIL stall_beats: got %0d beats exp B0 B1 B2", acc_q.size()); end
        @(negedge clk); #1;
        chk++; if (grant !== 2'd2 || m_tdata !== beat(2, 8'hC0)) begin fail++; $display("FAIL stall_next: grant %0d exp 2", grant); end
        @(negedge clk); drive(2, 1'b0, 1'b0, 8'h00); #1;
        chk++; if (stat !== {32'd0, 32'd1, 32'd1, 32'd0}) begin fail++; $display("FAIL stall_counts: got %h exp 0/1/1/0", stat); end
    endtask
    task automatic test_port_en();
        logic [1:0] exp_g [6];
        exp_g = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        do_reset();
        @(negedge clk); en = 4'b1011;
        for (int n = 0; n < 4; n++) drive(n, 1'b1, 1'b1, 8'(n));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk++; if (grant !== exp_g[k]) begin fail++; $display("FAIL en_grant%0d: got %0d exp %0d", k, grant, exp_g[k]); end
            @(negedge clk);
            if (k == 5) for (int n = 0; n < 4; n++) drive(n, 1'b0, 1'b0, 8'h00);
        end
        #1;
        chk++; if (stat[95:64] !== 32'd0) begin fail++; $display("FAIL en_port2_cnt: got %0d exp 0", stat[95:64]); end
        do_reset();
        @(negedge clk); drive(1, 1'b1, 1'b0, 8'hD0);
        @(negedge clk); #1;
        chk++; if (grant !== 2'd1 || busy !== 1'b1) begin fail++; $display("FAIL en_mid_start: grant %0d busy %b exp 1 1", grant, busy); end
        @(negedge clk); en = 4'b1101; drive(1, 1'b0, 1'b0, 8'hD1); #1;
        chk++; if (busy !== 1'b1 || m_tvalid !== 1'b0 || grant !== 2'd1) begin fail++; $display("FAIL en_mid_stall: busy %b tvalid %b grant %0d exp 1 0 1", busy, m_tvalid, grant); end
        @(negedge clk); drive(1, 1'b1, 1'b0, 8'hD1); #1;
        chk++; if (m_tvalid !== 1'b1 || s_tready !== 4'b0010) begin fail++; $display("FAIL en_mid_resume: tvalid %b tready %b exp 1 0010", m_tvalid, s_tready); end
        @(negedge clk); drive(1, 1'b1, 1'b1, 8'hD2);
        @(negedge clk); drive(1, 1'b0, 1'b0, 8'h00); #1;
        chk++; if (busy !== 1'b0 || stat[63:32] !== 32'd1 || acc_q.size() != 3) begin fail++; $display("FAIL en_mid_done: busy %b cnt1 %0d beats %0d exp 0 1 3", busy, stat[63:32], acc_q.size()); end
    endtask
    task automatic test_no_eligible();
        do_reset();
        @(negedge clk); drive(2, 1'b1, 1'b1, 8'h22);
        @(negedge clk); #1;
        chk++; if (grant !== 2'd2) begin fail++; $display("FAIL noel_first: got %0d exp 2", grant); end
        @(negedge clk); en = 4'b0000;
        for (int n = 0; n < 4; n++) drive(n, 1'b1, 1'b1, 8'(n));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk++; if (busy !== 1'b0 || grant !== 2'd2) begin fail++; $display("FAIL noel_idle%0d: busy %b grant %0d exp 0 2", k, busy, grant); end
        end
        en = 4'hF;
        @(negedge clk); #1;
        chk++; if (grant !== 2'd3 || busy !== 1'b1) begin fail++; $display("FAIL noel_resume: grant %0d busy %b exp 3 1", grant, busy); end
        @(negedge clk);
        for (int n = 0; n < 4; n++) drive(n, 1'b0, 1'b0, 8'h00);
    endtask
    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        force dut.cnt = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
        #1 release dut.cnt;
        #1;
        chk++; if (stat !== 128'hFFFF_FFFF) begin fail++; $display("FAIL wrap_preload: got %h exp ffffffff", stat); end
        drive(0, 1'b1, 1'b1, 8'hEE);
        @(negedge clk); #1;
        chk++; if (busy !== 1'b1 || grant !== 2'd0) begin fail++; $display("FAIL wrap_grant: busy %b grant %0d exp 1 0", busy, grant); end
        @(negedge clk); drive(0, 1'b0, 1'b0, 8'h00); #1;
        chk++; if (stat !== 128'h0) begin fail++; $display("FAIL wrap_cnt: got %h exp 0", stat); end
    endtask
    task automatic test_reset_mid();
        do_reset();
        @(negedge clk); drive(1, 1'b1, 1'b1, 8'h11);
        @(negedge clk); #1;
        chk++; if (grant !== 2'd1) begin fail++; $display("FAIL rmid_pre: got %0d exp 1", grant); end
        @(negedge clk); drive(1, 1'b0, 1'b0, 8'h00); drive(0, 1'b1, 1'b0, 8'h40);
        @(negedge clk); #1;
        chk++; if (grant !== 2'd0 || stat[63:32] !== 32'd1) begin fail++; $display("FAIL rmid_start: grant %0d cnt1 %0d exp 0 1", grant, stat[63:32]); end
        @(negedge clk); drive(0, 1'b1, 1'b0, 8'h41);
        @(negedge clk); drive(0, 1'b1, 1'b0, 8'h42); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 4; n++) drive(n, 1'b1, 1'b0, 8'(n));
        #1;
        chk++; if (s_tready !== 4'h0 || m_tvalid !== 1'b0 || busy !== 1'b0) begin fail++; $display("FAIL rmid_outputs: tready %b tvalid %b busy %b exp 0000 0 0", s_tready, m_tvalid, busy); end
        chk++; if (stat !== 128'h0) begin fail++; $display("FAIL rmid_stat: got %h exp 0", stat); end
        @(negedge clk); #1;
        chk++; if (grant !== 2'd0 || busy !== 1'b1) begin fail++; $display("FAIL rmid_regrant: grant %0d busy %b exp 0 1", grant, busy); end
        for (int n = 0; n < 4; n++) drive(n, 1'b0, 1'b0, 8'h00);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        m_tready = 1'b1;
        en = 4'hF;
        for (int n = 0; n < 4; n++) drive(n, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_basic();
        test_all_ports();
        test_stall();
        test_port_en();
        test_no_eligible();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, fail);
        $finish;
    end
endmodule
